pwm_duty_ramp_ctrl: RTL and testbench



---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_step_timer.sv | 34 +++
 rtl/pwm_duty_ramp_ctrl.sv | 119 +++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty range, default widths, and the ramp FSM state type.
// Also used by the PWM generator and the button debouncer.
package pwm_pkg;

  localparam int DUTY_W    = 4;
  localparam int DUTY_MAX  = 10;
  localparam int DUTY_INIT = 5;
  localparam int IVL_W     = 16;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_step_timer.sv
// Counts period_end pulses while enabled and emits a one-cycle step pulse
// on the pulse that brings the count up to the interval.
module pwm_step_timer #(
  parameter int IVL_W = pwm_pkg::IVL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             period_end,
  input  logic [IVL_W-1:0] interval,
  output logic             step
);

  logic [IVL_W-1:0] count;
  logic [IVL_W:0]   count_next;
  logic             reached;

  // One extra bit so the comparison stays correct at the largest interval.
  assign count_next = {1'b0, count} + {{IVL_W{1'b0}}, 1'b1};
  assign reached    = (count_next >= {1'b0, interval});
  assign step       = enable && period_end && reached;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || step) begin
      count <= '0;
    end else if (enable && period_end) begin
      count <= count_next[IVL_W-1:0];
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle sequencer: accepts a target/interval command and ramps duty_out
// by one step per interval PWM periods, changing only on period boundaries.
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W    = pwm_pkg::DUTY_W,
  parameter int DUTY_MAX  = pwm_pkg::DUTY_MAX,
  parameter int DUTY_INIT = pwm_pkg::DUTY_INIT,
  parameter int IVL_W     = pwm_pkg::IVL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [IVL_W-1:0]  cmd_interval,
  input  logic              abort,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done,
  output logic              fsm_state
);

  import pwm_pkg::*;

  // Command handshake: a command transfers on any clock edge where
  // cmd_valid && cmd_ready; the requester holds cmd_valid until then.

  localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_D = DUTY_W'(DUTY_INIT);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d, tgt_in;
  logic [IVL_W-1:0]  ivl_q, ivl_d, ivl_in;
  logic              done_q, done_d;
  logic              timer_clear;
  logic              step;

  assign tgt_in = (cmd_target > MAX_D) ? MAX_D : cmd_target;
  assign ivl_in = (cmd_interval == '0) ? IVL_W'(1) : cmd_interval;

  // Kept independent of the step pulse so there is no combinational loop
  // through the timer.
  assign timer_clear = ((state_q == IDLE) && cmd_valid) ||
                       ((state_q == RAMP) && abort);

  pwm_step_timer #(
    .IVL_W (IVL_W)
  ) u_step_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .enable     (state_q == RAMP),
    .period_end (period_end),
    .interval   (ivl_q),
    .step       (step)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    ivl_d   = ivl_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_d = tgt_in;
          ivl_d = ivl_in;
          if (tgt_in == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        // Abort takes priority over a step landing in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (step) begin
          if ((tgt_q > duty_q) && (duty_q < MAX_D)) begin
            duty_d = duty_q + 1'b1;
          end else if ((tgt_q < duty_q) && (duty_q != '0)) begin
            duty_d = duty_q - 1'b1;
          end
          if (duty_d == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= INIT_D;
      tgt_q   <= INIT_D;
      ivl_q   <= IVL_W'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      ivl_q   <= ivl_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RAMP);
  assign done      = done_q;
  assign duty_out  = duty_q;
  assign fsm_state = (state_q == RAMP);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Bench for pwm_duty_ramp_ctrl: directed scenarios then random commands,
// checked by an event scoreboard fed from a period-counting reference model.
module tb_pwm_duty_ramp_ctrl;

  localparam int DW = 4;
  localparam int IW = 16;
  localparam int EW = DW + 1;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_target;
  logic [IW-1:0] cmd_interval;
  logic          abort;
  logic          period_end;
  logic [DW-1:0] duty_out;
  logic          busy;
  logic          done;
  logic          fsm_state;

  pwm_duty_ramp_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_target   (cmd_target),
    .cmd_interval (cmd_interval),
    .abort        (abort),
    .period_end   (period_end),
    .duty_out     (duty_out),
    .busy         (busy),
    .done         (done),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  // Reference model: counts period_end pulses since accept.
  int m_duty   = 5;
  int m_tgt    = 5;
  int m_ivl    = 1;
  int m_cnt    = 0;
  bit m_active = 0;

  function automatic logic [EW-1:0] make_ev(input bit d, input int v);
    logic [31:0] vv;
    vv = v;
    return {d, vv[DW-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [DW-1:0] prev;
    logic [EW-1:0] ev, e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        prev = duty_out;
      end else if ((duty_out !== prev) || (done === 1'b1)) begin
        ev = {done, duty_out};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got=%0h exp=none", ev);
        end else begin
          e = exp_q.pop_front();
          if (ev !== e) begin
            failures++;
            $display("FAIL event got=%0h exp=%0h", ev, e);
          end
        end
        check("duty_in_range", duty_out <= 4'd10, 1);
        if (done === 1'b1) begin
          check("ready_with_done", cmd_ready, 1);
          check("busy_low_with_done", busy, 0);
        end
        prev = duty_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    #1;
    check(name, exp_q.size(), 0);
    check("busy_vs_model", busy, m_active);
    check("state_vs_model", fsm_state, m_active);
  endtask

  task automatic send_cmd(input int tgt, input int ivl, input bit pe_acc);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid    = 1'b1;
    cmd_target   = tgt[DW-1:0];
    cmd_interval = ivl[IW-1:0];
    period_end   = pe_acc;
    tick();
    cmd_valid  = 1'b0;
    period_end = 1'b0;
    m_tgt = (tgt > 10) ? 10 : tgt;
    m_ivl = (ivl == 0) ? 1 : ivl;
    if (m_tgt == m_duty) begin
      exp_q.push_back(make_ev(1'b1, m_duty));
    end else begin
      m_active = 1;
      m_cnt    = 0;
    end
    drain("cmd_response");
  endtask

  task automatic pulse_pe(input bit ab, input int gap);
    repeat (gap) tick();
    period_end = 1'b1;
    abort      = ab;
    tick();
    period_end = 1'b0;
    abort      = 1'b0;
    if (m_active) begin
      if (ab) begin
        m_active = 0;
      end else begin
        m_cnt++;
        if (m_cnt == m_ivl) begin
          m_cnt  = 0;
          m_duty = m_duty + ((m_tgt > m_duty) ? 1 : -1);
          exp_q.push_back(make_ev(m_duty == m_tgt, m_duty));
          if (m_duty == m_tgt) m_active = 0;
        end
      end
    end
    drain("pe_response");
  endtask

  task automatic poke_cmd();
    check("ready_low_in_ramp", cmd_ready, 0);
    cmd_valid  = 1'b1;
    cmd_target = DW'($urandom_range(0, 10));
    tick();
    cmd_valid = 1'b0;
    drain("poke_response");
  endtask

  task automatic abort_only();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (m_active) begin
      m_active = 0;
    end
    drain("abort_response");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b0;
    cmd_valid    = 1'b0;
    cmd_target   = '0;
    cmd_interval = '0;
    abort        = 1'b0;
    period_end   = 1'b0;

    // Asynchronous reset, observed before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset_duty", duty_out, 5);
    check("reset_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (2) tick();
    rst    = 1'b0;
    mon_en = 1;
    tick();

    // Ramp up 5 -> 8, one step per period.
    send_cmd(8, 1, 1'b0);
    repeat (3) pulse_pe(1'b0, 9);
    check("up_final", duty_out, 8);

    // Back to 5, then slow ramp down with ignored requests mid-ramp.
    send_cmd(5, 1, 1'b0);
    repeat (3) pulse_pe(1'b0, 9);
    send_cmd(2, 3, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i == 2 || i == 5) poke_cmd();
      pulse_pe(1'b0, 9);
    end
    check("down_final", duty_out, 2);

    // Clamped target and zero interval; period_end in accept cycle ignored.
    send_cmd(15, 0, 1'b1);
    repeat (8) pulse_pe(1'b0, 9);
    check("clamp_final", duty_out, 10);
    pulse_pe(1'b0, 9);
    check("clamp_no_wrap", duty_out, 10);

    // Abort coincident with a stepping period_end.
    send_cmd(5, 1, 1'b0);
    repeat (5) pulse_pe(1'b0, 9);
    send_cmd(9, 1, 1'b0);
    pulse_pe(1'b0, 9);
    pulse_pe(1'b0, 9);
    pulse_pe(1'b1, 9);
    check("abort_hold", duty_out, 7);
    check("abort_ready", cmd_ready, 1);
    abort_only();
    send_cmd(7, 1, 1'b0);

    // Reset in the middle of a 0 -> 10 ramp at duty 4.
    send_cmd(0, 1, 1'b0);
    repeat (7) pulse_pe(1'b0, 9);
    send_cmd(10, 1, 1'b0);
    repeat (4) pulse_pe(1'b0, 9);
    check("pre_reset_duty", duty_out, 4);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("midramp_reset_duty", duty_out, 5);
    check("midramp_reset_ready", cmd_ready, 1);
    check("midramp_reset_busy", busy, 0);
    m_duty   = 5;
    m_active = 0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (3) pulse_pe(1'b0, 9);

    // Random commands, period spacing and aborts.
    for (int n = 0; n < 25; n++) begin
      send_cmd($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      while (m_active) begin
        if ($urandom_range(0, 9) == 0) poke_cmd();
        pulse_pe($urandom_range(0, 11) == 0, $urandom_range(0, 6));
      end
    end

    repeat (3) tick();
    check("queue_empty_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
